fu_div: RTL and testbench
=========================

// Module: fu_div
// PURPOSE
//  Iterative integer divide unit for RV32M DIV/DIVU/REM/REMU.
//  Sits directly downstream of the reservation station: it consumes one issued rs_data entry at a time.
//  Source operand values arrive from the physical register file in the issue cycle.
//  It produces one writeback (pd, value, rob_index) towards the CDB/ROB, and squashes its op on mispredict.
// PARAMETERS
//  XLEN       32   operand/result width
//  ROB_DEPTH  16   ROB entries; rob_index/tags wrap modulo ROB_DEPTH
//  PREG_W     7    physical register tag width (128 pregs)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       asynchronous, active-low reset
//  issue_valid    in   1       RS issues an op this cycle (rs fu_issued)
//  issue_pd       in   PREG_W  destination preg
//  issue_rob_idx  in   5       ROB index of op
//  issue_func3    in   3       100 DIV, 101 DIVU, 110 REM, 111 REMU
//  rs1_val        in   XLEN    dividend (PRF read, valid with issue_valid)
//  rs2_val        in   XLEN    divisor
//  fu_ready       out  1       unit can accept an op this cycle
//  wb_valid       out  1       result valid, held until wb_ready
//  wb_ready       in   1       CDB grants writeback
//  wb_pd          out  PREG_W  destination preg of result
//  wb_rob_idx     out  5       ROB index of result
//  wb_data        out  XLEN    quotient or remainder
//  rob_head       in   5       current ROB head, used for age compare
//  mispredict     in   1       branch mispredict pulse
//  mispredict_tag in   5       ROB index of mispredicted branch
// BEHAVIOUR
//  States: IDLE, BUSY, FIX, DONE. Reset (reset=0, async): state=IDLE, counter=0, fu_ready=1, wb_valid=0,
//   wb_pd=0, wb_rob_idx=0, wb_data=0.
//  fu_ready = (state==IDLE), combinational. Accept on edge where issue_valid && fu_ready; issue_valid while
//   !fu_ready is a protocol error (ignored, no state change).
//  Accept: latch pd, rob_idx, func3; signed ops take |rs1|,|rs2| and record result sign
//   (DIV: sign(rs1)^sign(rs2); REM: sign(rs1)). Then:
//   - divisor==0: DONE next; quotient=all ones, remainder=rs1 unmodified.
//   - signed op, rs1==0x8000_0000, rs2==-1: DONE next; DIV=0x8000_0000, REM=0.
//   - else BUSY, counter=0.
//  BUSY: one restoring radix-2 step per cycle (shift remainder in MSB of dividend, trial subtract, set
//   quotient bit); counter increments; after step 31 (counter==XLEN-1) -> FIX.
//  FIX: apply two's-complement negation per recorded sign, select quotient (func3[1]=0) or remainder
//   (func3[1]=1) into wb_data -> DONE.
//  DONE: wb_valid=1, wb_* stable; on wb_valid && wb_ready -> IDLE (fu_ready high next cycle).
//   No back-to-back accept in the handoff cycle.
//  Latency: normal op wb_valid first high 34 cycles after the accept edge; special cases 1 cycle.
//  Flush: op is younger iff (op_rob_idx-rob_head) mod ROB_DEPTH > (mispredict_tag-rob_head) mod ROB_DEPTH.
//   On mispredict in BUSY/FIX/DONE with a younger op: -> IDLE, wb_valid=0 next cycle, no writeback.
//   Mispredict with a simultaneous wb handshake: the handshake completes (the op is older or is killed
//   first; kill takes priority and wb is suppressed only if younger). Mispredict in the accept cycle with a
//   younger issue_rob_idx: op is not accepted.
//   Older op or equal tag: unaffected.
//  Reset asserted mid-operation: immediate IDLE; partial result discarded.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined: at accept, if |rs1| < |rs2| (after sign handling, divisor!=0), skip BUSY:
//   -> FIX next cycle with quotient=0, remainder=|rs1|; latency 2 cycles.
//  Undefined: such ops take the full 34-cycle path; results are identical in both builds.
// TESTING
//  DIVU 100/7, wb_ready=1 -> wb_data=14 exactly 34 cycles after accept; fu_ready low during op.
//  DIV -7/2 -> -3; REM -7/2 -> -1; REMU 0xFFFF_FFFF/16 -> 15.
//  DIV x/0 -> 0xFFFF_FFFF in 1 cycle; REM 5/0 -> 5; DIV 0x8000_0000/-1 -> 0x8000_0000, REM -> 0.
//  rob_head=14, op rob_idx=1, mispredict_tag=0 at cycle 10 of BUSY -> no wb_valid, fu_ready next cycle;
//   same op with tag=2 -> completes normally.
//  wb_ready held low 5 cycles in DONE -> wb_valid/wb_data stable, single handshake; reset low mid-BUSY
//   -> fu_ready=1, wb_valid=0 at once.
//  With DIV_EARLY_OUT_EN: DIVU 3/10 -> q=0 at 2 cycles; without it -> same value at 34 cycles.

Source files
------------

// File: rtl/fu_div.sv
// Iterative radix-2 RV32M divide unit (DIV/DIVU/REM/REMU) with ROB-age flush.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module fu_div #(
    parameter int XLEN      = 32,
    parameter int ROB_DEPTH = 16,
    parameter int PREG_W    = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [PREG_W-1:0] issue_pd,
    input  logic [4:0]        issue_rob_idx,
    input  logic [2:0]        issue_func3,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    output logic              fu_ready,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [PREG_W-1:0] wb_pd,
    output logic [4:0]        wb_rob_idx,
    output logic [XLEN-1:0]   wb_data,
    input  logic [4:0]        rob_head,
    input  logic              mispredict,
    input  logic [4:0]        mispredict_tag
);

    localparam int AW = $clog2(ROB_DEPTH);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [PREG_W-1:0] pd_q;
    logic [4:0]        rob_q;
    logic              rem_sel_q;
    logic              neg_q;
    logic [XLEN-1:0]   dvd_q;
    logic [XLEN-1:0]   dvs_q;
    logic [XLEN-1:0]   rem_q;

    // Age relative to the ROB head; larger distance means younger.
    function automatic logic younger(input logic [4:0] idx);
        return AW'(idx - rob_head) > AW'(mispredict_tag - rob_head);
    endfunction

    logic            kill;
    logic            accept;
    logic            is_signed;
    logic            is_rem;
    logic            a_neg;
    logic            b_neg;
    logic            res_neg;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;

    assign fu_ready = (state == S_IDLE);
    assign kill     = mispredict && (state != S_IDLE) && younger(rob_q);
    assign accept   = issue_valid && fu_ready
                    && !(mispredict && younger(issue_rob_idx));
    assign wb_valid = (state == S_DONE) && !kill;
    assign wb_pd      = pd_q;
    assign wb_rob_idx = rob_q;

    assign is_signed = ~issue_func3[0];
    assign is_rem    = issue_func3[1];
    assign a_neg     = is_signed & rs1_val[XLEN-1];
    assign b_neg     = is_signed & rs2_val[XLEN-1];
    assign res_neg   = is_rem ? a_neg : (a_neg ^ b_neg);
    assign abs_a     = a_neg ? -rs1_val : rs1_val;
    assign abs_b     = b_neg ? -rs2_val : rs2_val;
    assign div0      = (rs2_val == '0);
    assign ovf       = is_signed && (rs1_val == MIN) && (rs2_val == '1);

    logic unused_f3;
    assign unused_f3 = issue_func3[2];

    // One restoring step: shift in next dividend bit, trial subtract.
    logic [XLEN-1:0] rem_sh;
    logic [XLEN:0]   trial;
    logic            ge;
    logic [XLEN-1:0] sel;
    logic [XLEN-1:0] fix_res;

    assign rem_sh  = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
    assign trial   = {1'b0, rem_sh} - {1'b0, dvs_q};
    assign ge      = ~trial[XLEN];
    assign sel     = rem_sel_q ? rem_q : dvd_q;
    assign fix_res = neg_q ? -sel : sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pd_q      <= '0;
            rob_q     <= '0;
            rem_sel_q <= 1'b0;
            neg_q     <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            wb_data   <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (accept) begin
                    pd_q      <= issue_pd;
                    rob_q     <= issue_rob_idx;
                    rem_sel_q <= is_rem;
                    neg_q     <= res_neg;
                    cnt       <= '0;
                    if (div0) begin
                        wb_data <= is_rem ? rs1_val : '1;
                        state   <= S_DONE;
                    end else if (ovf) begin
                        wb_data <= is_rem ? '0 : MIN;
                        state   <= S_DONE;
                    end else
`ifdef DIV_EARLY_OUT_EN
                    if (abs_a < abs_b) begin
                        dvd_q <= '0;
                        rem_q <= abs_a;
                        state <= S_FIX;
                    end else
`endif
                    begin
                        dvd_q <= abs_a;
                        dvs_q <= abs_b;
                        rem_q <= '0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: if (kill) begin
                    state <= S_IDLE;
                end else begin
                    rem_q <= ge ? trial[XLEN-1:0] : rem_sh;
                    dvd_q <= {dvd_q[XLEN-2:0], ge};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_FIX;
                end
                S_FIX: if (kill) begin
                    state <= S_IDLE;
                end else begin
                    wb_data <= fix_res;
                    state   <= S_DONE;
                end
                S_DONE: if (kill || wb_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fu_div.sv
// Randomised and directed bench for fu_div against an arithmetic reference model.
// Build with DIV_EARLY_OUT_EN defined to exercise the early-out latency.
module tb_fu_div;

    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [6:0]  issue_pd;
    logic [4:0]  issue_rob_idx;
    logic [2:0]  issue_func3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        fu_ready;
    logic        wb_valid;
    logic        wb_ready;
    logic [6:0]  wb_pd;
    logic [4:0]  wb_rob_idx;
    logic [31:0] wb_data;
    logic [4:0]  rob_head;
    logic        mispredict;
    logic [4:0]  mispredict_tag;

    int checks = 0;
    int errors = 0;

    fu_div dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_pd(issue_pd),
        .issue_rob_idx(issue_rob_idx), .issue_func3(issue_func3),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .fu_ready(fu_ready), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_pd(wb_pd), .wb_rob_idx(wb_rob_idx), .wb_data(wb_data),
        .rob_head(rob_head), .mispredict(mispredict),
        .mispredict_tag(mispredict_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic ov;
        ov = (a == MIN) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ov ? MIN
                         : 32'($signed(a) / $signed(b));
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ov ? 32'd0
                         : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        logic [31:0] ma, mb;
        if (b == 0) return 1;
        if (!f3[0] && a == MIN && b == 32'hFFFF_FFFF) return 1;
        ma = (!f3[0] && a[31]) ? 32'd0 - a : a;
        mb = (!f3[0] && b[31]) ? 32'd0 - b : b;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 2;
`else
        if (ma < mb) return 34;
`endif
        return 34;
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rob,
                         input logic [6:0] pd);
        issue_func3 = f3; rs1_val = a; rs2_val = b;
        issue_rob_idx = rob; issue_pd = pd; issue_valid = 1'b1;
        @(posedge clk); #1;
        issue_valid = 1'b0;
    endtask

    task automatic wait_wb(output int lat);
        lat = 1;
        while (!wb_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [4:0] rob;
        logic [6:0] pd;
        rob = 5'($urandom_range(0, 15));
        pd  = 7'($urandom);
        issue(f3, a, b, rob, pd);
        chk({tag, "_busy"}, 32'(fu_ready), 32'(lat == 1 && wb_valid));
        wait_wb(lat);
        chk({tag, "_lat"}, lat, ref_lat(f3, a, b));
        chk({tag, "_data"}, wb_data, ref_res(f3, a, b));
        chk({tag, "_tags"}, {wb_pd, wb_rob_idx}, {pd, rob});
        @(posedge clk); #1;
        chk({tag, "_idle"}, {wb_valid, fu_ready}, 2'b01);
    endtask

    task automatic kill_test(input string tag, input logic [4:0] tag_idx,
                             input logic expect_kill);
        int lat;
        int seen;
        rob_head = 5'd14;
        issue(3'b101, 32'd1000, 32'd3, 5'd1, 7'd9);
        lat = 1;
        repeat (10) begin @(posedge clk); #1; lat++; end
        mispredict = 1'b1; mispredict_tag = tag_idx;
        @(posedge clk); #1; lat++;
        mispredict = 1'b0;
        if (expect_kill) begin
            chk({tag, "_flush"}, {wb_valid, fu_ready}, 2'b01);
            seen = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (wb_valid) seen++;
            end
            chk({tag, "_nowb"}, seen, 0);
        end else begin
            while (!wb_valid && lat < 100) begin
                @(posedge clk); #1; lat++;
            end
            chk({tag, "_lat"}, lat, 34);
            chk({tag, "_data"}, wb_data, 32'd333);
            @(posedge clk); #1;
        end
        rob_head = 5'd0;
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        logic [2:0] f3;
        logic [31:0] a, b;
        int sel;
        int stable;

        reset = 1'b0; issue_valid = 1'b0; issue_pd = '0;
        issue_rob_idx = '0; issue_func3 = 3'b100; rs1_val = '0;
        rs2_val = '0; wb_ready = 1'b1; rob_head = '0;
        mispredict = 1'b0; mispredict_tag = '0;
        #12;
        chk("rst_ready", 32'(fu_ready), 32'd1);
        chk("rst_wb", {wb_valid, wb_pd, wb_rob_idx}, '0);
        chk("rst_data", wb_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_op("divu100_7", 3'b101, 32'd100, 32'd7);
        run_op("div_m7_2", 3'b100, -32'sd7, 32'd2);
        run_op("rem_m7_2", 3'b110, -32'sd7, 32'd2);
        run_op("remu_max16", 3'b111, 32'hFFFF_FFFF, 32'd16);
        run_op("div_x_0", 3'b100, 32'd1234, 32'd0);
        run_op("rem_5_0", 3'b110, 32'd5, 32'd0);
        run_op("div_ovf", 3'b100, MIN, 32'hFFFF_FFFF);
        run_op("rem_ovf", 3'b110, MIN, 32'hFFFF_FFFF);
        run_op("divu_3_10", 3'b101, 32'd3, 32'd10);
        run_op("rem_m3_10", 3'b110, -32'sd3, 32'd10);

        kill_test("kill_young", 5'd0, 1'b1);
        kill_test("keep_old", 5'd2, 1'b0);

        // Mispredict in the accept cycle with a younger op: not taken.
        rob_head = 5'd0; mispredict = 1'b1; mispredict_tag = 5'd3;
        issue(3'b101, 32'd50, 32'd5, 5'd7, 7'd1);
        mispredict = 1'b0;
        chk("acc_kill", {wb_valid, fu_ready}, 2'b01);

        wb_ready = 1'b0;
        issue(3'b101, 32'd999, 32'd10, 5'd4, 7'd5);
        wait_wb(lat);
        held = wb_data;
        chk("stall_data", held, 32'd99);
        stable = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (wb_valid && wb_data === held) stable++;
        end
        chk("stall_hold", stable, 5);
        wb_ready = 1'b1;
        @(posedge clk); #1;
        stable = 0;
        repeat (5) begin
            if (wb_valid) stable++;
            @(posedge clk); #1;
        end
        chk("single_hs", {stable, 31'(fu_ready)}, {32'd0, 31'd1});

        issue(3'b100, 32'd77777, 32'd13, 5'd2, 7'd3);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid", {wb_valid, fu_ready}, 2'b01);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            f3  = 3'($urandom_range(4, 7));
            sel = $urandom_range(0, 7);
            a = $urandom; b = $urandom;
            case (sel)
                0: b = 32'd0;
                1: begin a = MIN; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: begin a = 32'($urandom_range(0, 9));
                         b = 32'($urandom_range(10, 500)); end
                default: ;
            endcase
            run_op("rand", f3, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
